// File: rtl/recepcao_serial_pkg.sv
// Purpose: shared types and constants for the serial receive path.
// Contents: control FSM state codes, RX FSM states, 8N1 frame constants,
//           default baud divider and RAM frame geometry.
package recepcao_serial_pkg;

    // Default divider: 50 MHz clock at 9600 baud
    localparam int unsigned CICLOS_POR_BIT_PADRAO = 5208;

    // 8N1 framing
    localparam int unsigned BITS_DADOS    = 8;
    localparam logic        NIVEL_PARADA  = 1'b1;

    // Frame geometry and RAM port widths
    localparam int unsigned LINES_PADRAO   = 3;
    localparam int unsigned COLUMNS_PADRAO = 3;
    localparam int unsigned S_DATA         = 16;
    localparam int unsigned S_LINE         = 2;
    localparam int unsigned S_COLUMN       = 2;

    // Control FSM codes, visible on db_estado
    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        ESPERA_LSB = 4'd1,
        ESPERA_MSB = 4'd2,
        ESCREVE    = 4'd3,
        PROXIMO    = 4'd4,
        FIM        = 4'd5
    } estado_t;

    // Receiver FSM states
    typedef enum logic [2:0] {
        RX_OCIOSO      = 3'd0,
        RX_INICIO      = 3'd1,
        RX_DADOS       = 3'd2,
        RX_PARADA      = 3'd3,
        RX_ESPERA_ALTO = 3'd4
    } estado_rx_t;

endpackage

// File: rtl/recepcao_serial_if.sv
// Purpose: RAM write port carried from the receiver to the pixel RAM.
// Signals: we (1-cycle write pulse), addr_linha, addr_coluna, dados.
// Modports: master = driver (receiver), slave = RAM side / observer.
interface recepcao_serial_if;
    import recepcao_serial_pkg::*;

    logic                we;
    logic [S_LINE-1:0]   addr_linha;
    logic [S_COLUMN-1:0] addr_coluna;
    logic [S_DATA-1:0]   dados;

    modport master (
        output we,
        output addr_linha,
        output addr_coluna,
        output dados
    );

    modport slave (
        input we,
        input addr_linha,
        input addr_coluna,
        input dados
    );

endinterface

// File: rtl/recepcao_serial_contador_m.sv
// Purpose: modulo-M counter used for the RAM line and column addresses.
// Ports: clock, reset (async, active-low), zera (sync clear), conta (advance),
//        valor (current count), fim_c (combinational: valor == M-1).
module contador_m #(
    parameter int unsigned M = 3,
    parameter int unsigned W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] valor,
    output logic         fim_c
);

    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] valor_q;
    logic [W-1:0] valor_d;

    assign fim_c = (valor_q == ULTIMO);
    assign valor = valor_q;

    // Next count: clear wins, wrap at M-1
    always_comb begin
        valor_d = valor_q;
        if (zera) begin
            valor_d = '0;
        end else if (conta) begin
            valor_d = fim_c ? '0 : valor_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

endmodule

// File: rtl/recepcao_serial_rx_serial_8n1.sv
// Purpose: 8N1 UART receiver, LSB first, idle-high line.
// Ports: clock, reset (async, active-low), entrada_serial (raw RX line),
//        dado_rx (last good byte), byte_valido (1-cycle pulse), erro_byte (1-cycle pulse).
module rx_serial_8n1
    import recepcao_serial_pkg::*;
#(
    parameter int unsigned CICLOS_POR_BIT = CICLOS_POR_BIT_PADRAO
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  entrada_serial,
    output logic [BITS_DADOS-1:0] dado_rx,
    output logic                  byte_valido,
    output logic                  erro_byte
);

    localparam int unsigned W_CNT  = $clog2(CICLOS_POR_BIT);
    localparam int unsigned W_BITS = $clog2(BITS_DADOS);
    localparam logic [W_CNT-1:0]  FIM_BIT    = W_CNT'(CICLOS_POR_BIT - 1);
    localparam logic [W_CNT-1:0]  MEIO_BIT   = W_CNT'(CICLOS_POR_BIT / 2 - 1);
    localparam logic [W_BITS-1:0] ULTIMO_BIT = W_BITS'(BITS_DADOS - 1);

    estado_rx_t            estado_q, estado_d;
    logic [W_CNT-1:0]      cnt_q, cnt_d;
    logic [W_BITS-1:0]     nbit_q, nbit_d;
    logic [BITS_DADOS-1:0] desloc_q, desloc_d;
    logic [BITS_DADOS-1:0] dado_q, dado_d;
    logic                  valido_q, valido_d;
    logic                  erro_q, erro_d;
    logic [1:0]            sinc_q;
    logic                  rx;

    // Two-flop synchroniser; resets to the idle (high) level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_q <= 2'b11;
        end else begin
            sinc_q <= {sinc_q[0], entrada_serial};
        end
    end

    assign rx = sinc_q[1];

    // Baud timing, bit sampling and framing check
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        nbit_d   = nbit_q;
        desloc_d = desloc_q;
        dado_d   = dado_q;
        valido_d = 1'b0;
        erro_d   = 1'b0;
        unique case (estado_q)
            RX_OCIOSO: begin
                cnt_d = '0;
                if (!rx) begin
                    estado_d = RX_INICIO;
                end
            end
            RX_INICIO: begin
                // Resample half a bit later to reject short glitches
                if (cnt_q == MEIO_BIT) begin
                    cnt_d    = '0;
                    nbit_d   = '0;
                    estado_d = rx ? RX_OCIOSO : RX_DADOS;
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end
            RX_DADOS: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d    = '0;
                    desloc_d = {rx, desloc_q[BITS_DADOS-1:1]};
                    if (nbit_q == ULTIMO_BIT) begin
                        estado_d = RX_PARADA;
                    end else begin
                        nbit_d = nbit_q + W_BITS'(1);
                    end
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end
            RX_PARADA: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d = '0;
                    if (rx == NIVEL_PARADA) begin
                        dado_d   = desloc_q;
                        valido_d = 1'b1;
                        estado_d = RX_OCIOSO;
                    end else begin
                        erro_d   = 1'b1;
                        estado_d = RX_ESPERA_ALTO;
                    end
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end
            RX_ESPERA_ALTO: begin
                // Bad stop bit: resync only once the line returns high
                if (rx) begin
                    estado_d = RX_OCIOSO;
                end
            end
            default: estado_d = RX_OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= RX_OCIOSO;
            cnt_q    <= '0;
            nbit_q   <= '0;
            desloc_q <= '0;
            dado_q   <= '0;
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            nbit_q   <= nbit_d;
            desloc_q <= desloc_d;
            dado_q   <= dado_d;
            valido_q <= valido_d;
            erro_q   <= erro_d;
        end
    end

    assign dado_rx     = dado_q;
    assign byte_valido = valido_q;
    assign erro_byte   = erro_q;

endmodule

// File: rtl/recepcao_serial.sv
// Purpose: receive one 3x3 face over the serial line and write it to pixel RAM, row-major.
// Ports: clock, reset (async, active-low), iniciar (arm pulse), entrada_serial (RX line),
//        ram (RAM write port: we, addr_linha, addr_coluna, dados), ocupado, pronto,
//        erro_parada (sticky stop-bit error), db_estado (FSM code).
module recepcao_serial
    import recepcao_serial_pkg::*;
#(
    parameter int unsigned CICLOS_POR_BIT = CICLOS_POR_BIT_PADRAO,
    parameter int unsigned LINES          = LINES_PADRAO,
    parameter int unsigned COLUMNS        = COLUMNS_PADRAO
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iniciar,
    input  logic                     entrada_serial,
    recepcao_serial_if.master        ram,
    output logic                     ocupado,
    output logic                     pronto,
    output logic                     erro_parada,
    output logic [3:0]               db_estado
);

    logic [BITS_DADOS-1:0] dado_rx;
    logic                  byte_valido;
    logic                  erro_byte;

    estado_t               estado_q, estado_d;
    logic [BITS_DADOS-1:0] lsb_q, lsb_d;
    logic [S_DATA-1:0]     dados_q, dados_d;
    logic [S_LINE-1:0]     linha_q, linha_d;
    logic [S_COLUMN-1:0]   coluna_q, coluna_d;
    logic                  we_q, we_d;
    logic                  pronto_q, pronto_d;
    logic                  ocupado_q, ocupado_d;
    logic                  erro_q, erro_d;
    logic [3:0]            db_estado_q, db_estado_d;

    logic                  zera_c;
    logic                  conta_col_c;
    logic                  conta_lin_c;
    logic [S_LINE-1:0]     cnt_linha;
    logic [S_COLUMN-1:0]   cnt_coluna;
    logic                  fim_linha_c;
    logic                  fim_coluna_c;

    rx_serial_8n1 #(
        .CICLOS_POR_BIT (CICLOS_POR_BIT)
    ) u_rx (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .dado_rx        (dado_rx),
        .byte_valido    (byte_valido),
        .erro_byte      (erro_byte)
    );

    contador_m #(
        .M (COLUMNS),
        .W (S_COLUMN)
    ) u_coluna (
        .clock (clock),
        .reset (reset),
        .zera  (zera_c),
        .conta (conta_col_c),
        .valor (cnt_coluna),
        .fim_c (fim_coluna_c)
    );

    contador_m #(
        .M (LINES),
        .W (S_LINE)
    ) u_linha (
        .clock (clock),
        .reset (reset),
        .zera  (zera_c),
        .conta (conta_lin_c),
        .valor (cnt_linha),
        .fim_c (fim_linha_c)
    );

    // Control FSM; registered outputs are computed from the next state
    always_comb begin
        estado_d    = estado_q;
        lsb_d       = lsb_q;
        dados_d     = dados_q;
        linha_d     = linha_q;
        coluna_d    = coluna_q;
        erro_d      = erro_q;
        zera_c      = 1'b0;
        conta_col_c = 1'b0;
        conta_lin_c = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    zera_c   = 1'b1;
                    erro_d   = 1'b0;
                    estado_d = ESPERA_LSB;
                end
            end
            ESPERA_LSB: begin
                if (erro_byte) begin
                    erro_d   = 1'b1;
                    estado_d = OCIOSO;
                end else if (byte_valido) begin
                    lsb_d    = dado_rx;
                    estado_d = ESPERA_MSB;
                end
            end
            ESPERA_MSB: begin
                if (erro_byte) begin
                    erro_d   = 1'b1;
                    estado_d = OCIOSO;
                end else if (byte_valido) begin
                    dados_d  = {dado_rx, lsb_q};
                    linha_d  = cnt_linha;
                    coluna_d = cnt_coluna;
                    estado_d = ESCREVE;
                end
            end
            ESCREVE: begin
                estado_d = PROXIMO;
            end
            PROXIMO: begin
                conta_col_c = 1'b1;
                conta_lin_c = fim_coluna_c;
                estado_d    = (fim_coluna_c && fim_linha_c) ? FIM : ESPERA_LSB;
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
        we_d        = (estado_d == ESCREVE);
        pronto_d    = (estado_d == FIM);
        ocupado_d   = (estado_d != OCIOSO);
        db_estado_d = estado_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            lsb_q       <= '0;
            dados_q     <= '0;
            linha_q     <= '0;
            coluna_q    <= '0;
            we_q        <= 1'b0;
            pronto_q    <= 1'b0;
            ocupado_q   <= 1'b0;
            erro_q      <= 1'b0;
            db_estado_q <= '0;
        end else begin
            estado_q    <= estado_d;
            lsb_q       <= lsb_d;
            dados_q     <= dados_d;
            linha_q     <= linha_d;
            coluna_q    <= coluna_d;
            we_q        <= we_d;
            pronto_q    <= pronto_d;
            ocupado_q   <= ocupado_d;
            erro_q      <= erro_d;
            db_estado_q <= db_estado_d;
        end
    end

    assign ram.we          = we_q;
    assign ram.addr_linha  = linha_q;
    assign ram.addr_coluna = coluna_q;
    assign ram.dados       = dados_q;
    assign ocupado         = ocupado_q;
    assign pronto          = pronto_q;
    assign erro_parada     = erro_q;
    assign db_estado       = db_estado_q;

endmodule

// File: tb/tb_recepcao_serial.sv
// Purpose: self-checking bench for recepcao_serial with a fast baud divider.
// A scoreboard of expected RAM writes is built from the bytes sent; a monitor
// checks every write pulse against it, directed checks cover control outputs.
module tb_recepcao_serial;
    import recepcao_serial_pkg::*;

    localparam int unsigned CPB = 16;

    logic       clock          = 1'b0;
    logic       reset          = 1'b1;
    logic       iniciar        = 1'b0;
    logic       entrada_serial = 1'b1;
    logic       ocupado;
    logic       pronto;
    logic       erro_parada;
    logic [3:0] db_estado;

    recepcao_serial_if ram_if ();

    recepcao_serial #(
        .CICLOS_POR_BIT (CPB),
        .LINES          (3),
        .COLUMNS        (3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (iniciar),
        .entrada_serial (entrada_serial),
        .ram            (ram_if),
        .ocupado        (ocupado),
        .pronto         (pronto),
        .erro_parada    (erro_parada),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          l;
        int          c;
        logic [15:0] d;
    } escrita_t;

    escrita_t    exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          ciclo = 0;
    int          n_we = 0;
    int          n_pronto = 0;
    int          ciclo_we = 0;
    int          ciclo_pronto = 0;
    logic [15:0] primeiro_dado = '0;
    logic [15:0] ultimo_dado = '0;
    int          ultimo_l = -1;
    int          ultimo_c = -1;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, esperado);
        end
    endtask

    // Every-cycle monitor: write pulses against the scoreboard, pronto timing
    task automatic monitor();
        escrita_t e;
        forever begin
            @(negedge clock);
            ciclo++;
            if (reset) begin
                chk("ocupado_vs_estado", 32'(ocupado), 32'(db_estado != 4'd0));
                chk("estado_valido", 32'(db_estado <= 4'd5), 32'd1);
                if (ram_if.we) begin
                    n_we++;
                    ciclo_we = ciclo;
                    if (exp_q.size() == 0) begin
                        chk("we_inesperado", 32'(ram_if.we), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("addr_linha", 32'(ram_if.addr_linha), 32'(e.l));
                        chk("addr_coluna", 32'(ram_if.addr_coluna), 32'(e.c));
                        chk("dados", 32'(ram_if.dados), 32'(e.d));
                        if (e.l == 0 && e.c == 0) primeiro_dado = ram_if.dados;
                        ultimo_dado = ram_if.dados;
                        ultimo_l    = 32'(ram_if.addr_linha);
                        ultimo_c    = 32'(ram_if.addr_coluna);
                    end
                end
                if (pronto) begin
                    n_pronto++;
                    ciclo_pronto = ciclo;
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic parada = 1'b1);
        entrada_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            entrada_serial = b[i];
            repeat (CPB) @(negedge clock);
        end
        entrada_serial = parada;
        repeat (CPB) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic pulse_iniciar();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // Expected writes: word k = {byte 2k+1, byte 2k} at (k/3, k%3)
    task automatic push_frame(input logic [7:0] base, input int npal);
        escrita_t e;
        logic [7:0] lo, hi;
        for (int k = 0; k < npal; k++) begin
            lo  = base + 8'(2 * k);
            hi  = base + 8'(2 * k + 1);
            e.l = k / 3;
            e.c = k % 3;
            e.d = {hi, lo};
            exp_q.push_back(e);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_we", 32'(ram_if.we), 32'd0);
        chk("rst_addr_linha", 32'(ram_if.addr_linha), 32'd0);
        chk("rst_addr_coluna", 32'(ram_if.addr_coluna), 32'd0);
        chk("rst_dados", 32'(ram_if.dados), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_pronto", 32'(pronto), 32'd0);
        chk("rst_erro", 32'(erro_parada), 32'd0);
        chk("rst_estado", 32'(db_estado), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // Short low glitch on idle line
        entrada_serial = 1'b0;
        repeat (5) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (40) @(negedge clock);
        chk("glitch_ocioso_estado", 32'(db_estado), 32'd0);

        // Bytes before iniciar are discarded
        send_byte(8'hA5);
        send_byte(8'h5A);
        chk("pre_iniciar_n_we", 32'(n_we), 32'd0);
        chk("pre_iniciar_ocupado", 32'(ocupado), 32'd0);

        // Full frame 0x00..0x11 with an ignored iniciar mid-frame
        pulse_iniciar();
        chk("iniciar_ocupado", 32'(ocupado), 32'd1);
        chk("iniciar_estado", 32'(db_estado), 32'd1);
        push_frame(8'h00, 9);
        for (int i = 0; i < 18; i++) begin
            send_byte(8'(i));
            if (i == 0) chk("apos_lsb_estado", 32'(db_estado), 32'd2);
            if (i == 7) begin
                pulse_iniciar();
                chk("iniciar_ignorado_estado", 32'(db_estado), 32'd1);
            end
        end
        repeat (10) @(negedge clock);
        chk("f1_n_we", 32'(n_we), 32'd9);
        chk("f1_fila_vazia", 32'(exp_q.size()), 32'd0);
        chk("f1_n_pronto", 32'(n_pronto), 32'd1);
        chk("f1_pronto_atraso", 32'(ciclo_pronto - ciclo_we), 32'd2);
        chk("f1_ocupado", 32'(ocupado), 32'd0);
        chk("f1_estado", 32'(db_estado), 32'd0);
        chk("f1_erro", 32'(erro_parada), 32'd0);
        chk("f1_primeiro", 32'(primeiro_dado), 32'h0100);
        chk("f1_ultimo", 32'(ultimo_dado), 32'h1110);
        chk("f1_ultimo_l", 32'(ultimo_l), 32'd2);
        chk("f1_ultimo_c", 32'(ultimo_c), 32'd2);
        chk("f1_hold_linha", 32'(ram_if.addr_linha), 32'd2);
        chk("f1_hold_coluna", 32'(ram_if.addr_coluna), 32'd2);
        chk("f1_hold_dados", 32'(ram_if.dados), 32'h1110);

        // Stop-bit error on second byte aborts the frame
        pulse_iniciar();
        send_byte(8'h33);
        send_byte(8'h44, 1'b0);
        repeat (4) @(negedge clock);
        chk("erro_parada", 32'(erro_parada), 32'd1);
        chk("erro_estado", 32'(db_estado), 32'd0);
        chk("erro_ocupado", 32'(ocupado), 32'd0);
        chk("erro_n_we", 32'(n_we), 32'd9);
        chk("erro_n_pronto", 32'(n_pronto), 32'd1);
        pulse_iniciar();
        chk("erro_limpo", 32'(erro_parada), 32'd0);
        chk("rearme_estado", 32'(db_estado), 32'd1);

        // Glitch while waiting for a byte
        entrada_serial = 1'b0;
        repeat (5) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (40) @(negedge clock);
        chk("glitch_espera_estado", 32'(db_estado), 32'd1);

        // Four words, then reset mid-frame
        push_frame(8'h40, 4);
        for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i));
        chk("parcial_n_we", 32'(n_we), 32'd13);
        chk("parcial_fila_vazia", 32'(exp_q.size()), 32'd0);
        chk("parcial_dados", 32'(ram_if.dados), 32'h4746);
        reset = 1'b0;
        #1;
        chk("rst2_we", 32'(ram_if.we), 32'd0);
        chk("rst2_addr_linha", 32'(ram_if.addr_linha), 32'd0);
        chk("rst2_addr_coluna", 32'(ram_if.addr_coluna), 32'd0);
        chk("rst2_dados", 32'(ram_if.dados), 32'd0);
        chk("rst2_ocupado", 32'(ocupado), 32'd0);
        chk("rst2_pronto", 32'(pronto), 32'd0);
        chk("rst2_erro", 32'(erro_parada), 32'd0);
        chk("rst2_estado", 32'(db_estado), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // New frame restarts at (0,0)
        pulse_iniciar();
        push_frame(8'h80, 9);
        for (int i = 0; i < 18; i++) send_byte(8'h80 + 8'(i));
        repeat (10) @(negedge clock);
        chk("f2_n_we", 32'(n_we), 32'd22);
        chk("f2_fila_vazia", 32'(exp_q.size()), 32'd0);
        chk("f2_n_pronto", 32'(n_pronto), 32'd2);
        chk("f2_primeiro", 32'(primeiro_dado), 32'h8180);
        chk("f2_ultimo", 32'(ultimo_dado), 32'h9190);
        chk("f2_ocupado", 32'(ocupado), 32'd0);
        chk("f2_erro", 32'(erro_parada), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
